// File: rtl/l2_dc_responder_pkg.sv
// Shared types and constants for the L2 dcache responder: state encoding,
// bus widths, read/write encodings and default timing.
package l2_dc_responder_pkg;

  localparam int unsigned L2_LINE_BUS    = 128;
  localparam int unsigned L2_ADDR_BUS    = 32;
  localparam int unsigned L2_OFFSET_W    = 4;
  localparam int unsigned L2_LAT_DEFAULT = 2;

  localparam logic L2_RW_READ  = 1'b0;
  localparam logic L2_RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_ACCESS   = 3'd2,
    ST_FILL     = 3'd3,
    ST_WAIT_CPL = 3'd4,
    ST_DONE     = 3'd5
  } l2_state_e;

endpackage

// File: rtl/l2_dc_responder.sv
// L2-side responder for L1 dcache line fills and dirty-line writebacks.
// Latches one request, sequences it onto the backing store, returns fills to L1.
module l2_dc_responder
  import l2_dc_responder_pkg::*;
#(
  parameter int unsigned L2_LAT = L2_LAT_DEFAULT,
  parameter int unsigned LINE_W = L2_LINE_BUS,
  parameter int unsigned ADDR_W = L2_ADDR_BUS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              drq,
  input  logic              l2_cache_rw,
  input  logic [ADDR_W-1:0] l2_addr,
  input  logic [LINE_W-1:0] rd_to_l2,
  input  logic              complete,
  output logic              l2_busy,
  output logic              l2_rdy,
  output logic              mem_wr_dc_en,
  output logic [LINE_W-1:0] l2_rd_line,
  output logic              l2_complete,
  output logic              bs_req,
  output logic              bs_rw,
  output logic [ADDR_W-1:0] bs_addr,
  output logic [LINE_W-1:0] bs_wd,
  input  logic              bs_ack,
  input  logic [LINE_W-1:0] bs_rd
);

  localparam int unsigned CNT_W = $clog2(L2_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(L2_LAT - 1);
  localparam int unsigned LA_W = ADDR_W - L2_OFFSET_W;

  l2_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [LA_W-1:0]    addr_q;
  logic               rw_q;
  logic [LINE_W-1:0]  wd_q;
  logic [LINE_W-1:0]  line_q;
  logic               turn;

  // Offset bits never reach the backing store.
  logic unused_offset;
  assign unused_offset = ^l2_addr[L2_OFFSET_W-1:0];

  assign bs_rw      = rw_q;
  assign bs_addr    = {addr_q, {L2_OFFSET_W{1'b0}}};
  assign bs_wd      = wd_q;
  assign l2_rd_line = line_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      wd_q         <= '0;
      line_q       <= '0;
      turn         <= 1'b0;
      l2_busy      <= 1'b0;
      l2_rdy       <= 1'b0;
      mem_wr_dc_en <= 1'b0;
      l2_complete  <= 1'b0;
      bs_req       <= 1'b0;
    end else begin
      l2_rdy       <= 1'b0;
      mem_wr_dc_en <= 1'b0;
      l2_complete  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // First IDLE cycle after DONE: L1 is still dropping drq.
          if (turn) begin
            turn <= 1'b0;
          end else if (drq) begin
            addr_q  <= l2_addr[ADDR_W-1:L2_OFFSET_W];
            rw_q    <= l2_cache_rw;
            // Write data only loaded on writebacks so bs_wd stays stable across fills.
            if (l2_cache_rw == L2_RW_WRITE) wd_q <= rd_to_l2;
            cnt     <= CNT_INIT;
            l2_busy <= 1'b1;
            state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (cnt == '0) begin
            bs_req <= 1'b1;
            state  <= ST_ACCESS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ACCESS: begin
          if (bs_ack) begin
            bs_req <= 1'b0;
            if (rw_q == L2_RW_READ) begin
              line_q       <= bs_rd;
              l2_rdy       <= 1'b1;
              mem_wr_dc_en <= 1'b1;
              state        <= ST_FILL;
            end else begin
              l2_complete <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_FILL: begin
          state <= ST_WAIT_CPL;
        end
        ST_WAIT_CPL: begin
          if (complete) begin
            l2_complete <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          l2_busy <= 1'b0;
          turn    <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          l2_busy <= 1'b0;
          bs_req  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
